// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instruction memory, fills the IF/ID register.
// Out-of-range fetches are captured as bubbles with a fault flag.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 512,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  pc_src_e,
  input  logic [ADDR_WIDTH-1:0] pc_target_e,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr_f,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic                  fetch_fault_d
);

  localparam int unsigned WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] MEM_WORDS = WW'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  valid;
    logic                  fault;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0,
    fault:    1'b0
  };

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_n;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target_al;
  logic                  in_range;

  if_id_t if_id_q;
  if_id_t if_id_n;
  if_id_t fetched;

  assign pc_plus4  = pc_q + FOUR;
  assign target_al = {pc_target_e[ADDR_WIDTH-1:2], 2'b00};
  assign in_range  = pc_q[ADDR_WIDTH-1:2] < MEM_WORDS;

  // Redirect beats stall: a taken branch must never be lost to a stall.
  always_comb begin
    pc_n = pc_plus4;
    if (pc_src_e) begin
      pc_n = target_al;
    end else if (stall_f) begin
      pc_n = pc_q;
    end
  end

  always_comb begin
    fetched          = BUBBLE;
    fetched.instr    = in_range ? instr_f : NOP_INSTR;
    fetched.pc       = pc_q;
    fetched.pc_plus4 = pc_plus4;
    fetched.valid    = 1'b1;
    fetched.fault    = ~in_range;
  end

  always_comb begin
    if_id_n = fetched;
    if (flush_d) begin
      if_id_n = BUBBLE;
    end else if (stall_d) begin
      if_id_n = if_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= BUBBLE;
    end else begin
      pc_q    <= pc_n;
      if_id_q <= if_id_n;
    end
  end

  assign instr_addr    = pc_q;
  assign pc_f          = pc_q;
  assign instr_d       = if_id_q.instr;
  assign pc_d          = if_id_q.pc;
  assign pc_plus4_d    = if_id_q.pc_plus4;
  assign valid_d       = if_id_q.valid;
  assign fetch_fault_d = if_id_q.fault;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined RV32I core. Owns the program counter and drives the instruction-memory address.
- Instruction memory is a combinational word-aligned read, indexed by addr[31:2]. This block captures its returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls and flushes, plus branch/jump redirects from EX.

Parameters:
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, PC and address width
- MEM_SIZE, 512, instruction memory depth in words; used for the fetch range check
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- stall_f  input  1  hold PC (hazard unit)
- stall_d  input  1  hold IF/ID register
- flush_d  input  1  replace IF/ID contents with bubble
- pc_src_e  input  1  redirect request from EX (taken branch/jump)
- pc_target_e  input  ADDR_WIDTH  redirect target from EX
- instr_addr  output  ADDR_WIDTH  address to instruction memory; equals pc_f
- instr_f  input  DATA_WIDTH  word returned combinationally by instruction memory
- pc_f  output  ADDR_WIDTH  current fetch PC
- instr_d  output  DATA_WIDTH  IF/ID instruction
- pc_d  output  ADDR_WIDTH  IF/ID PC
- pc_plus4_d  output  ADDR_WIDTH  IF/ID PC+4
- valid_d  output  1  IF/ID holds a real fetched instruction
- fetch_fault_d  output  1  IF/ID instruction was fetched outside memory range

Behaviour:
- One clock domain. All state updates on the rising clk edge. Reset is sampled only at the edge (synchronous, active-low).
- Reset (reset_n=0 at edge), all outputs:
  - pc_f = RESET_PC
  - instr_d = NOP_INSTR
  - pc_d = 0
  - pc_plus4_d = 0
  - valid_d = 0
  - fetch_fault_d = 0
- Reset mid-operation overrides stall, flush and redirect in the same cycle.
- instr_addr = pc_f, combinational. Total fetch latency: PC to instr_d is 1 cycle.
- Next-PC priority, highest first:
  1. reset → RESET_PC
  2. pc_src_e=1 → {pc_target_e[31:2], 2'b00}. Low two bits are forced to zero. Redirect wins over stall_f.
  3. stall_f=1 → pc_f holds
  4. otherwise → pc_f + 4
- Arithmetic: pc_f + 4 is modulo 2^ADDR_WIDTH, so 32'hFFFFFFFC wraps to 0. No carry-out or flag.
- Range check: in_range = (pc_f[31:2] < MEM_SIZE).
  - If out of range, the captured instruction is NOP_INSTR regardless of instr_f, and fetch_fault_d=1 at capture.
  - The PC still advances normally.
- IF/ID priority, highest first:
  1. reset → reset values above
  2. flush_d=1 → instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_fault_d=0. Flush wins over stall_d.
  3. stall_d=1 → all IF/ID outputs hold
  4. otherwise → instr_d = (in_range ? instr_f : NOP_INSTR), pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, fetch_fault_d=!in_range
- pc_src_e does not itself flush IF/ID. The hazard unit asserts flush_d alongside pc_src_e.
- stall_f=1 with stall_d=0 is legal and not expected from the hazard unit. In that case IF/ID re-captures the same pc_f each cycle.
- First cycle after reset release: pc_f=RESET_PC, valid_d=0. Next edge captures word 0 with valid_d=1.
- No combinational path from instr_f to any output.

Test Plan:
- Reset then free-run, bench memory word[n]=32'hA0000000+n:
  - edge 1 after release → instr_d=A0000000, pc_d=0, pc_plus4_d=4, valid_d=1
  - edge 3 → instr_d=A0000002, pc_d=8
- stall_f=stall_d=1 for 3 cycles at pc_f=0x10 → pc_f stays 0x10; instr_d/pc_d hold 0x0C values. On release the sequence resumes at 0x10 with no skipped or duplicated word.
- Redirect: pc_src_e=1, pc_target_e=0x40, flush_d=1 in the same cycle as stall_f=1:
  - next edge → pc_f=0x40, instr_d=00000013, valid_d=0
  - following edge → instr_d=A0000010, pc_d=0x40
- Misaligned target 0x43 → pc_f=0x40.
- Out-of-range: redirect to MEM_SIZE*4 = 0x800 → captured instr_d=00000013, fetch_fault_d=1, pc_d=0x800, pc_f advances to 0x804.
- Wrap: redirect to 0xFFFFFFFC → next pc_f=0x00000000, pc_plus4_d=0x00000000; fault flagged for 0xFFFFFFFC.
- Reset mid-run with stall_f=1, pc_src_e=1, flush_d=0:
  - pc_f=RESET_PC, valid_d=0, instr_d=00000013 at that edge
  - with reset_n low and no edge yet, outputs unchanged
